id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage core, between decode and execute.
- Captures decoded fields and register-file operands.
- Applies the forwarding unit's write-through bypass (MEM/WB write landing in the same cycle as the RF read) at capture.
- Detects load-use hazards, inserts bubbles, and applies branch flushes.
- Its ex_rs1/ex_rs2/ex_rd/ex_rd1/ex_rd2 outputs feed the forwarding unit and the EX stage.

---
 rtl/id_ex_stage.sv | 128 ++++++++++++
 tb/tb_id_ex_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with write-through bypass, load-use stall and branch flush
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             ex_branch_taken,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [XLEN-1:0]  id_rf_rd1,
    input  logic [XLEN-1:0]  id_rf_rd2,
    input  logic             id_rf_we,
    input  logic             id_mem_re,
    input  logic             id_mem_we,
    input  logic [3:0]       id_alu_op,
    input  logic [1:0]       id_wb_sel,
    input  logic             rd1_i_sel,
    input  logic             rd2_i_sel,
    input  logic [XLEN-1:0]  fwd_rd1_i,
    input  logic [XLEN-1:0]  fwd_rd2_i,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [XLEN-1:0]  ex_rd1,
    output logic [XLEN-1:0]  ex_rd2,
    output logic             ex_rf_we,
    output logic             ex_mem_re,
    output logic             ex_mem_we,
    output logic [3:0]       ex_alu_op,
    output logic [1:0]       ex_wb_sel,
    output logic             stall_if,
    output logic             flush_if_id,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic load_use;
    logic rs1_hit;
    logic rs2_hit;
    logic bubble;

    // A bubble has ex_rd=0, so it can never trigger a load-use match on the next cycle.
    assign rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
    assign load_use = id_valid & ex_valid & ex_mem_re & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

    assign stall_if    = load_use & ~ex_branch_taken & ~hold;
    assign flush_if_id = ex_branch_taken & ~hold;
    assign bubble      = ex_branch_taken | load_use | ~id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_imm    <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rd     <= '0;
            ex_rd1    <= '0;
            ex_rd2    <= '0;
            ex_rf_we  <= 1'b0;
            ex_mem_re <= 1'b0;
            ex_mem_we <= 1'b0;
            ex_alu_op <= '0;
            ex_wb_sel <= '0;
        end else if (!hold) begin
            if (bubble) begin
                ex_valid  <= 1'b0;
                ex_pc     <= '0;
                ex_imm    <= '0;
                ex_rs1    <= '0;
                ex_rs2    <= '0;
                ex_rd     <= '0;
                ex_rd1    <= '0;
                ex_rd2    <= '0;
                ex_rf_we  <= 1'b0;
                ex_mem_re <= 1'b0;
                ex_mem_we <= 1'b0;
                ex_alu_op <= '0;
                ex_wb_sel <= '0;
            end else begin
                ex_valid  <= 1'b1;
                ex_pc     <= id_pc;
                ex_imm    <= id_imm;
                ex_rs1    <= id_rs1;
                ex_rs2    <= id_rs2;
                ex_rd     <= id_rd;
                // MEM/WB write landing in the same cycle as the RF read
                ex_rd1    <= rd1_i_sel ? fwd_rd1_i : id_rf_rd1;
                ex_rd2    <= rd2_i_sel ? fwd_rd2_i : id_rf_rd2;
                ex_rf_we  <= id_rf_we;
                ex_mem_re <= id_mem_re;
                ex_mem_we <= id_mem_we;
                ex_alu_op <= id_alu_op;
                ex_wb_sel <= id_wb_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!hold) begin
            if (ex_branch_taken) begin
                if (flush_cnt != {CNT_W{1'b1}}) begin
                    flush_cnt <= flush_cnt + 1'b1;
                end
            end else if (load_use) begin
                if (stall_cnt != {CNT_W{1'b1}}) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage against a behavioural model
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic hold, ex_branch_taken, id_valid;
    logic [XLEN-1:0] id_pc, id_imm, id_rf_rd1, id_rf_rd2, fwd_rd1_i, fwd_rd2_i;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic id_use_rs1, id_use_rs2, id_rf_we, id_mem_re, id_mem_we, rd1_i_sel, rd2_i_sel;
    logic [3:0] id_alu_op;
    logic [1:0] id_wb_sel;
    logic ex_valid, ex_rf_we, ex_mem_re, ex_mem_we, stall_if, flush_if_id;
    logic [XLEN-1:0] ex_pc, ex_imm, ex_rd1, ex_rd2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0] ex_alu_op;
    logic [1:0] ex_wb_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .ex_branch_taken(ex_branch_taken),
        .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rf_rd1(id_rf_rd1), .id_rf_rd2(id_rf_rd2),
        .id_rf_we(id_rf_we), .id_mem_re(id_mem_re), .id_mem_we(id_mem_we),
        .id_alu_op(id_alu_op), .id_wb_sel(id_wb_sel),
        .rd1_i_sel(rd1_i_sel), .rd2_i_sel(rd2_i_sel),
        .fwd_rd1_i(fwd_rd1_i), .fwd_rd2_i(fwd_rd2_i),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_rf_we(ex_rf_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
        .ex_alu_op(ex_alu_op), .ex_wb_sel(ex_wb_sel),
        .stall_if(stall_if), .flush_if_id(flush_if_id),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, imm;
        logic [4:0]      rs1, rs2, rd;
        logic [XLEN-1:0] rd1, rd2;
        logic            rf_we, mem_re, mem_we;
        logic [3:0]      alu_op;
        logic [1:0]      wb_sel;
    } ex_t;

    typedef struct packed {
        logic            hold, br, valid;
        logic [XLEN-1:0] pc, imm;
        logic [4:0]      rs1, rs2, rd;
        logic            use1, use2;
        logic [XLEN-1:0] rf1, rf2;
        logic            rf_we, mem_re, mem_we;
        logic [3:0]      alu_op;
        logic [1:0]      wb_sel;
        logic            sel1, sel2;
        logic [XLEN-1:0] fwd1, fwd2;
    } in_t;

    typedef struct packed {
        logic             stall, flush;
        ex_t              ex;
        logic [CNT_W-1:0] sc, fc;
    } item_t;

    item_t q[$];
    ex_t m_ex;
    logic [CNT_W-1:0] m_sc, m_fc;
    int errors = 0;
    int checks = 0;
    bit stim_done = 0;
    bit mon_done = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ex_t dut_ex();
        ex_t e;
        e.valid = ex_valid;   e.pc = ex_pc;         e.imm = ex_imm;
        e.rs1 = ex_rs1;       e.rs2 = ex_rs2;       e.rd = ex_rd;
        e.rd1 = ex_rd1;       e.rd2 = ex_rd2;       e.rf_we = ex_rf_we;
        e.mem_re = ex_mem_re; e.mem_we = ex_mem_we; e.alu_op = ex_alu_op;
        e.wb_sel = ex_wb_sel;
        return e;
    endfunction

    task automatic drive(input in_t s);
        hold = s.hold;       ex_branch_taken = s.br; id_valid = s.valid;
        id_pc = s.pc;        id_imm = s.imm;
        id_rs1 = s.rs1;      id_rs2 = s.rs2;         id_rd = s.rd;
        id_use_rs1 = s.use1; id_use_rs2 = s.use2;
        id_rf_rd1 = s.rf1;   id_rf_rd2 = s.rf2;
        id_rf_we = s.rf_we;  id_mem_re = s.mem_re;   id_mem_we = s.mem_we;
        id_alu_op = s.alu_op; id_wb_sel = s.wb_sel;
        rd1_i_sel = s.sel1;  rd2_i_sel = s.sel2;
        fwd_rd1_i = s.fwd1;  fwd_rd2_i = s.fwd2;
    endtask

    // Reference: ID instruction waiting on a load still in EX must wait one cycle.
    task automatic step(input in_t s);
        item_t it;
        bit dep;
        dep = s.valid && m_ex.valid && m_ex.mem_re && m_ex.rd != 0 &&
              ((s.use1 && s.rs1 == m_ex.rd) || (s.use2 && s.rs2 == m_ex.rd));
        it.stall = dep && !s.br && !s.hold;
        it.flush = s.br && !s.hold;
        if (!s.hold) begin
            if (s.br) begin
                m_ex = '0;
                if (m_fc != {CNT_W{1'b1}}) m_fc = m_fc + 1;
            end else if (dep) begin
                m_ex = '0;
                if (m_sc != {CNT_W{1'b1}}) m_sc = m_sc + 1;
            end else if (!s.valid) begin
                m_ex = '0;
            end else begin
                m_ex.valid = 1'b1;   m_ex.pc = s.pc;   m_ex.imm = s.imm;
                m_ex.rs1 = s.rs1;    m_ex.rs2 = s.rs2; m_ex.rd = s.rd;
                m_ex.rd1 = s.sel1 ? s.fwd1 : s.rf1;
                m_ex.rd2 = s.sel2 ? s.fwd2 : s.rf2;
                m_ex.rf_we = s.rf_we; m_ex.mem_re = s.mem_re; m_ex.mem_we = s.mem_we;
                m_ex.alu_op = s.alu_op; m_ex.wb_sel = s.wb_sel;
            end
        end
        it.ex = m_ex;
        it.sc = m_sc;
        it.fc = m_fc;
        q.push_back(it);
    endtask

    task automatic apply(input in_t s);
        @(posedge clk);
        #2;
        drive(s);
        step(s);
    endtask

    function automatic in_t rnd();
        in_t s;
        s.hold = ($urandom_range(0, 9) == 0);
        s.br = ($urandom_range(0, 7) == 0);
        s.valid = ($urandom_range(0, 7) != 0);
        s.pc = $urandom;  s.imm = $urandom;
        s.rs1 = 5'($urandom_range(0, 7));
        s.rs2 = 5'($urandom_range(0, 7));
        s.rd = 5'($urandom_range(0, 7));
        s.use1 = 1'($urandom);  s.use2 = 1'($urandom);
        s.rf1 = $urandom;       s.rf2 = $urandom;
        s.rf_we = 1'($urandom); s.mem_re = 1'($urandom); s.mem_we = 1'($urandom);
        s.alu_op = 4'($urandom); s.wb_sel = 2'($urandom);
        s.sel1 = 1'($urandom);  s.sel2 = 1'($urandom);
        s.fwd1 = $urandom;      s.fwd2 = $urandom;
        return s;
    endfunction

    function automatic in_t load_x(input logic [4:0] rd);
        in_t s = '0;
        s.valid = 1'b1; s.pc = 32'h200; s.rd = rd; s.rs1 = 5'd2; s.use1 = 1'b1;
        s.mem_re = 1'b1; s.rf_we = 1'b1; s.wb_sel = 2'd1; s.imm = 32'h8;
        return s;
    endfunction

    function automatic in_t use_x(input logic [4:0] rs2, input logic use2);
        in_t s = '0;
        s.valid = 1'b1; s.pc = 32'h204; s.rs1 = 5'd1; s.use1 = 1'b1;
        s.rs2 = rs2; s.use2 = use2; s.rd = 5'd6; s.rf_we = 1'b1; s.alu_op = 4'd3;
        s.rf1 = 32'hA1; s.rf2 = 32'hB2;
        return s;
    endfunction

    initial begin : monitor
        item_t it;
        int waited;
        while (1) begin
            waited = 0;
            while (q.size() == 0 && !stim_done && waited < 200) begin
                #1;
                waited++;
            end
            if (q.size() == 0) begin
                if (!stim_done) begin
                    checks++;
                    errors++;
                    $display("FAIL monitor_timeout: got no item expected one within 200ns");
                end
                break;
            end
            it = q.pop_front();
            @(negedge clk);
            chk("stall_if", 160'(stall_if), 160'(it.stall));
            chk("flush_if_id", 160'(flush_if_id), 160'(it.flush));
            @(posedge clk);
            #1;
            chk("ex_regs", 160'(dut_ex()), 160'(it.ex));
            chk("stall_cnt", 160'(stall_cnt), 160'(it.sc));
            chk("flush_cnt", 160'(flush_cnt), 160'(it.fc));
        end
        mon_done = 1;
    end

    initial begin : stimulus
        in_t s;
        in_t cap;
        m_ex = '0; m_sc = '0; m_fc = '0;
        cap = '0;
        cap.valid = 1'b1; cap.pc = 32'h100; cap.rs1 = 5'd3; cap.rf1 = 32'h11;
        cap.sel1 = 1'b1; cap.fwd1 = 32'h55; cap.use1 = 1'b1;
        rst_n = 1'b0;
        drive(cap);
        repeat (2) @(negedge clk);
        chk("reset_ex_regs", 160'(dut_ex()), 160'(0));
        chk("reset_counters", 160'({stall_cnt, flush_cnt}), 160'(0));

        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(cap);
        step(cap);

        apply(load_x(5'd5));
        apply(use_x(5'd5, 1'b1));
        apply(use_x(5'd5, 1'b1));
        apply(load_x(5'd0));
        apply(use_x(5'd0, 1'b1));
        apply(load_x(5'd5));
        apply(use_x(5'd5, 1'b0));
        apply(load_x(5'd7));
        s = use_x(5'd7, 1'b1);
        s.br = 1'b1;
        apply(s);
        apply(load_x(5'd4));
        for (int i = 0; i < 3; i++) begin
            s = rnd();
            s.hold = 1'b1;
            s.br = 1'b1;
            apply(s);
        end
        for (int i = 0; i < 400; i++) apply(rnd());

        s = load_x(5'd5);
        s.rs2 = 5'd5;
        s.use2 = 1'b1;
        for (int i = 0; i < 2 * ((1 << CNT_W) + 2); i++) apply(s);
        @(posedge clk);
        #2;
        chk("stall_cnt_saturated", 160'(stall_cnt), 160'({CNT_W{1'b1}}));

        apply(load_x(5'd9));
        @(posedge clk);
        #2;
        drive(use_x(5'd9, 1'b1));
        #1;
        chk("stall_before_reset", 160'(stall_if), 160'(1));
        rst_n = 1'b0;
        #1;
        chk("midreset_ex_regs", 160'(dut_ex()), 160'(0));
        chk("midreset_stall_if", 160'({stall_if, stall_cnt, flush_cnt}), 160'(0));
        m_ex = '0; m_sc = '0; m_fc = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(use_x(5'd9, 1'b1));
        step(use_x(5'd9, 1'b1));
        for (int i = 0; i < 20; i++) apply(rnd());

        stim_done = 1;
        for (int i = 0; i < 400 && !mon_done; i++) #1;
        if (!mon_done) begin
            checks++;
            errors++;
            $display("FAIL monitor_drain: got pending=%0d expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
